// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the decode-stage issue/stall scheduler.
//   - RV32 major opcode constants (shared with the control unit)
//   - 2-bit FSM state encoding
//   - operand-usage decode: which source fields an opcode actually reads
package hazard_pkg;

    // Major opcodes, instr[6:0]
    localparam logic [6:0] OpR   = 7'b0110011;
    localparam logic [6:0] OpIOp = 7'b0010011;
    localparam logic [6:0] OpILd = 7'b0000011;
    localparam logic [6:0] OpU   = 7'b0110111;
    localparam logic [6:0] OpB   = 7'b1100011;
    localparam logic [6:0] OpJ   = 7'b1101111;
    localparam logic [6:0] OpS   = 7'b0100011;

    // FSM state encoding; the values are visible on state_out
    typedef logic [1:0] state_t;
    localparam state_t StRun   = 2'd0;
    localparam state_t StStall = 2'd1;
    localparam state_t StFlush = 2'd2;

    typedef struct packed {
        logic use_rs1;
        logic use_rs2;
    } src_use_t;

    // Unknown opcodes read nothing, so they can never stall.
    function automatic src_use_t decode_src_use(input logic [6:0] op);
        src_use_t u;
        u.use_rs1 = 1'b0;
        u.use_rs2 = 1'b0;
        case (op)
            OpR, OpS, OpB: begin
                u.use_rs1 = 1'b1;
                u.use_rs2 = 1'b1;
            end
            OpIOp, OpILd: u.use_rs1 = 1'b1;
            default: ;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: 32-entry table of pending-writeback counters and load flags.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   clear_i               synchronous clear of every entry
//   set_i/set_idx_i       start tracking a write to register set_idx_i (index 0 ignored)
//   set_lat_i/set_load_i  initial countdown and whether the writer is a load
//   rd_{a,b}_idx_i        read-port register indices
//   busy_{a,b}_o          counter nonzero
//   load_{a,b}_o          entry written by a load
//   cnt_{a,b}_o           raw counter value
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             set_i,
    input  logic [4:0]       set_idx_i,
    input  logic [CNT_W-1:0] set_lat_i,
    input  logic             set_load_i,
    input  logic [4:0]       rd_a_idx_i,
    output logic             busy_a_o,
    output logic             load_a_o,
    output logic [CNT_W-1:0] cnt_a_o,
    input  logic [4:0]       rd_b_idx_i,
    output logic             busy_b_o,
    output logic             load_b_o,
    output logic [CNT_W-1:0] cnt_b_o
);

    logic [CNT_W-1:0] cnt_q [32];
    logic [CNT_W-1:0] cnt_d [32];
    logic [31:0]      ld_q;
    logic [31:0]      ld_d;

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - CNT_W'(1) : '0;
            // Load flag lives only as long as its counter
            ld_d[i]  = ld_q[i] & (cnt_d[i] != '0);
            // A new write overrides the decrement on the same entry
            if (set_i && (set_idx_i != 5'd0) && (set_idx_i == 5'(i))) begin
                cnt_d[i] = set_lat_i;
                ld_d[i]  = set_load_i;
            end
            if (clear_i) begin
                cnt_d[i] = '0;
                ld_d[i]  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= '0;
            end
            ld_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            ld_q  <= ld_d;
        end
    end

    assign cnt_a_o  = cnt_q[rd_a_idx_i];
    assign busy_a_o = (cnt_q[rd_a_idx_i] != '0);
    assign load_a_o = ld_q[rd_a_idx_i];
    assign cnt_b_o  = cnt_q[rd_b_idx_i];
    assign busy_b_o = (cnt_q[rd_b_idx_i] != '0);
    assign load_b_o = ld_q[rd_b_idx_i];

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-stage issue/stall scheduler.
// Tracks pending writebacks in a scoreboard, detects RAW hazards on rs1/rs2 of the
// instruction in decode, freezes decode (rs_read) on stall or flush, and holds flush
// for FLUSH_CYCLES after a taken branch.
// Build option: HAZARD_FORWARD_EN -- forwarding exists downstream, so only a load
// issued in the previous cycle blocks its consumer.
// Ports:
//   req_1         clock
//   reset         asynchronous active-high reset
//   instr_valid   decode holds a valid instruction
//   opcode, rs1, rs2, rd, rd_write   fields of the instruction in decode
//   branch_taken  execute resolved a taken branch/jump
//   rs_read       freeze decode (stall | flush)
//   stall         RAW hazard, instruction not issued
//   flush         squash younger stages
//   issue         instruction leaves decode this cycle
//   state_out     FSM state for debug
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned WB_LAT       = 3,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 3
) (
    input  logic       req_1,
    input  logic       reset,
    input  logic       instr_valid,
    input  logic [6:0] opcode,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic [4:0] rd,
    input  logic       rd_write,
    input  logic       branch_taken,
    output logic       rs_read,
    output logic       stall,
    output logic       flush,
    output logic       issue,
    output logic [1:0] state_out
);

    localparam logic [CNT_W-1:0] LatCnt    = CNT_W'(WB_LAT);
    localparam logic [2:0]       FlushLoad = 3'(FLUSH_CYCLES);

    state_t     state_q, state_d;
    logic [2:0] fcnt_q, fcnt_d;

    src_use_t         src_use;
    logic             use1, use2;
    logic             busy_a, busy_b, load_a, load_b;
    logic [CNT_W-1:0] cnt_a, cnt_b;
    logic             hz_a, hz_b, hz;

    hazard_scoreboard #(
        .CNT_W (CNT_W)
    ) u_scoreboard (
        .clk_i      (req_1),
        .rst_i      (reset),
        .clear_i    (1'b0),
        .set_i      (issue & rd_write),
        .set_idx_i  (rd),
        .set_lat_i  (LatCnt),
        .set_load_i (opcode == OpILd),
        .rd_a_idx_i (rs1),
        .busy_a_o   (busy_a),
        .load_a_o   (load_a),
        .cnt_a_o    (cnt_a),
        .rd_b_idx_i (rs2),
        .busy_b_o   (busy_b),
        .load_b_o   (load_b),
        .cnt_b_o    (cnt_b)
    );

    assign src_use = decode_src_use(opcode);
    assign use1    = src_use.use_rs1 & (rs1 != 5'd0);
    assign use2    = src_use.use_rs2 & (rs2 != 5'd0);

`ifdef HAZARD_FORWARD_EN
    // Counter still at WB_LAT means the load issued last cycle: its data is not
    // yet forwardable, everything else is.
    assign hz_a = load_a & (cnt_a == LatCnt);
    assign hz_b = load_b & (cnt_b == LatCnt);
    logic unused_busy;
    assign unused_busy = busy_a ^ busy_b;
`else
    assign hz_a = busy_a;
    assign hz_b = busy_b;
    logic unused_fwd;
    assign unused_fwd = ^{load_a, load_b, cnt_a, cnt_b};
`endif

    assign hz = instr_valid & ((use1 & hz_a) | (use2 & hz_b));

    assign flush     = (state_q == StFlush);
    assign stall     = hz & (state_q != StFlush);
    assign issue     = instr_valid & ~hz & (state_q == StRun);
    assign rs_read   = stall | flush;
    assign state_out = state_q;

    // Taken branch has priority over hazards in every state.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            StRun: begin
                if (branch_taken) begin
                    state_d = StFlush;
                    fcnt_d  = FlushLoad;
                end else if (hz) begin
                    state_d = StStall;
                end
            end
            StStall: begin
                if (branch_taken) begin
                    state_d = StFlush;
                    fcnt_d  = FlushLoad;
                end else if (!hz) begin
                    state_d = StRun;
                end
            end
            StFlush: begin
                if (branch_taken) begin
                    fcnt_d = FlushLoad;
                end else if (fcnt_q <= 3'd1) begin
                    state_d = StRun;
                    fcnt_d  = 3'd0;
                end else begin
                    fcnt_d = fcnt_q - 3'd1;
                end
            end
            default: begin
                state_d = StRun;
                fcnt_d  = 3'd0;
            end
        endcase
    end

    always_ff @(posedge req_1 or posedge reset) begin
        if (reset) begin
            state_q <= StRun;
            fcnt_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard-style bench for hazard_ctrl.
// The reference model tracks absolute cycle stamps (when each register becomes
// readable, when a flush window ends) rather than counters.
module tb_hazard_ctrl;

    localparam int WB_LAT       = 3;
    localparam int FLUSH_CYCLES = 2;

    localparam logic [6:0] R   = 7'b0110011;
    localparam logic [6:0] IOP = 7'b0010011;
    localparam logic [6:0] ILD = 7'b0000011;
    localparam logic [6:0] UT  = 7'b0110111;
    localparam logic [6:0] BT  = 7'b1100011;
    localparam logic [6:0] JT  = 7'b1101111;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] BAD = 7'b1111111;

    logic       req_1 = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic [6:0] opcode;
    logic [4:0] rs1, rs2, rd;
    logic       rd_write;
    logic       branch_taken;
    logic       rs_read, stall, flush, issue;
    logic [1:0] state_out;

    hazard_ctrl #(
        .WB_LAT       (WB_LAT),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .CNT_W        (3)
    ) dut (
        .req_1        (req_1),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .opcode       (opcode),
        .rs1          (rs1),
        .rs2          (rs2),
        .rd           (rd),
        .rd_write     (rd_write),
        .branch_taken (branch_taken),
        .rs_read      (rs_read),
        .stall        (stall),
        .flush        (flush),
        .issue        (issue),
        .state_out    (state_out)
    );

    always #5 req_1 = ~req_1;

    typedef struct packed {
        logic       stall;
        logic       flush;
        logic       issue;
        logic [1:0] state;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   stall_seen = 0;

    // Reference model state
    int now = 0;
    int rdy[32];        // first cycle the register is readable again
    bit wl[32];         // latest write came from a load
    int wc[32];         // cycle the latest write issued
    int flush_end = 0;  // first cycle after the flush window
    bit stalled = 0;    // previous non-flush cycle saw a hazard

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit uses1(input logic [6:0] op);
        return op inside {R, IOP, ILD, ST, BT};
    endfunction

    function automatic bit uses2(input logic [6:0] op);
        return op inside {R, ST, BT};
    endfunction

    function automatic bit busy(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
`ifdef HAZARD_FORWARD_EN
        return wl[r] && (wc[r] == now - 1);
`else
        return rdy[r] > now;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            rdy[i] = 0;
            wl[i]  = 1'b0;
            wc[i]  = -100;
        end
        flush_end = 0;
        stalled   = 1'b0;
    endtask

    // Called at posedge+1: drive one cycle, queue its expectation, advance the model.
    task automatic cycle(input bit v, input logic [6:0] op, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] d, input bit w,
                         input bit br, output bit issued);
        bit   in_flush, hz;
        exp_t e;
        instr_valid  = v;
        opcode       = op;
        rs1          = a;
        rs2          = b;
        rd           = d;
        rd_write     = w;
        branch_taken = br;
        in_flush = (now < flush_end);
        hz = v && ((uses1(op) && busy(a)) || (uses2(op) && busy(b)));
        e.flush = in_flush;
        e.stall = hz && !in_flush;
        e.state = in_flush ? 2'd2 : (stalled ? 2'd1 : 2'd0);
        e.issue = v && !hz && (e.state == 2'd0);
        exp_q.push_back(e);
        issued = e.issue;
        @(posedge req_1);
        if (e.issue && w && d != 5'd0) begin
            rdy[d] = now + 1 + WB_LAT;
            wl[d]  = (op == ILD);
            wc[d]  = now;
        end
        if (br) begin
            flush_end = now + 1 + FLUSH_CYCLES;
            stalled   = 1'b0;
        end else if (in_flush) begin
            stalled = 1'b0;
        end else begin
            stalled = hz;
        end
        now++;
        #1;
    endtask

    // Present one instruction until it issues, bounded.
    task automatic hold(input string name, input logic [6:0] op, input logic [4:0] a,
                        input logic [4:0] b, input logic [4:0] d, input bit w);
        bit done = 1'b0;
        bit iss;
        for (int i = 0; i < 20 && !done; i++) begin
            cycle(1'b1, op, a, b, d, w, 1'b0, iss);
            done = iss;
        end
        if (!done) chk({name, "_issue_timeout"}, 0, 1);
    endtask

    always @(negedge req_1) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("stall", int'(stall), int'(e.stall));
            chk("flush", int'(flush), int'(e.flush));
            chk("issue", int'(issue), int'(e.issue));
            chk("state_out", int'(state_out), int'(e.state));
            chk("rs_read", int'(rs_read), int'(e.stall | e.flush));
        end
        if (stall === 1'b1) stall_seen++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit iss;
        logic [6:0] ops [8];
        int exp_stalls;
        ops = '{R, IOP, ILD, UT, BT, JT, ST, BAD};

        instr_valid = 0; opcode = R; rs1 = 0; rs2 = 0; rd = 0;
        rd_write = 0; branch_taken = 0;
        reset = 1'b1;
        model_reset();
        @(posedge req_1); @(posedge req_1); #1;
        chk("rst_stall", int'(stall), 0);
        chk("rst_flush", int'(flush), 0);
        chk("rst_issue", int'(issue), 0);
        chk("rst_rs_read", int'(rs_read), 0);
        chk("rst_state", int'(state_out), 0);
        reset = 1'b0;

        // Scoreboard empty after reset: consumers of every register issue at once
        stall_seen = 0;
        for (int r = 1; r < 6; r++) cycle(1'b1, R, 5'(r), 5'(r + 8), 5'd0, 1'b0, 1'b0, iss);
        chk("post_reset_stalls", stall_seen, 0);

        // Back-to-back RAW through rs1
        cycle(1'b1, R, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, iss);
        stall_seen = 0;
        hold("raw", R, 5'd5, 5'd3, 5'd6, 1'b1);
`ifdef HAZARD_FORWARD_EN
        exp_stalls = 0;
`else
        exp_stalls = WB_LAT;
`endif
        chk("raw_stall_cycles", stall_seen, exp_stalls);

        // Writes to x0 are never tracked
        cycle(1'b1, IOP, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, iss);
        stall_seen = 0;
        cycle(1'b1, IOP, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, iss);
        chk("x0_issue", int'(iss), 1);
        chk("x0_stall_cycles", stall_seen, 0);

        // Load-use through rs2 of a store
        cycle(1'b1, ILD, 5'd1, 5'd0, 5'd7, 1'b1, 1'b0, iss);
        stall_seen = 0;
        hold("ld_use", ST, 5'd2, 5'd7, 5'd0, 1'b0);
`ifdef HAZARD_FORWARD_EN
        exp_stalls = 1;
`else
        exp_stalls = WB_LAT;
`endif
        chk("ld_use_stall_cycles", stall_seen, exp_stalls);

        // ALU producer then the same store
        cycle(1'b1, R, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, iss);
        stall_seen = 0;
        hold("alu_use", ST, 5'd2, 5'd7, 5'd0, 1'b0);
`ifdef HAZARD_FORWARD_EN
        exp_stalls = 0;
`else
        exp_stalls = WB_LAT;
`endif
        chk("alu_use_stall_cycles", stall_seen, exp_stalls);

        // Taken branch while stalled (load producer so both builds stall first)
        cycle(1'b1, ILD, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, iss);
        cycle(1'b1, R, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, iss);
        cycle(1'b1, R, 5'd5, 5'd0, 5'd6, 1'b1, 1'b1, iss);
        for (int i = 0; i < FLUSH_CYCLES + 2; i++)
            cycle(1'b0, R, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, iss);

        // Async reset in the first flush cycle
        cycle(1'b1, R, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, iss);
        cycle(1'b0, R, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, iss);
        #1;
        chk("pre_reset_flush", int'(flush), 1);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_flush", int'(flush), 0);
        chk("async_rst_rs_read", int'(rs_read), 0);
        chk("async_rst_state", int'(state_out), 0);
        @(posedge req_1); @(posedge req_1); #1;
        reset = 1'b0;
        model_reset();
        stall_seen = 0;
        cycle(1'b1, R, 5'd9, 5'd9, 5'd3, 1'b1, 1'b0, iss);
        chk("post_async_rst_issue", int'(iss), 1);
        chk("post_async_rst_stall", stall_seen, 0);

        // Random traffic on a small register window to force frequent hazards
        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 9) != 0, ops[$urandom_range(0, 7)],
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 15) == 0, iss);
        end

        @(negedge req_1);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
